// File: rtl/whack_round_ctrl.sv
// Round controller for the box-hitting game: sensor debounce, LFSR target pick, response timer
// and scoring. Define WHACK_PENALTY_EN to treat wrong-box hits as misses that also cost a point.
module whack_round_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 50000000,
    parameter int unsigned ROUNDS          = 10,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] box_addr,
    output logic [2:0] target_box,
    output logic       round_active,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score,
    output logic [7:0] rounds_left,
    output logic       game_over
);

    localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DebW-1:0] DebPrev = DebW'(DEBOUNCE_CYCLES - 2);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      RoundsInit = 8'(ROUNDS);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWait,
        StHit,
        StMiss,
        StRelease,
        StDone
    } state_e;

    state_e          state_q;
    logic [2:0]      sample_q;
    logic [DebW-1:0] deb_cnt_q;
    logic [2:0]      stable_addr_q;
    logic [7:0]      lfsr_q;
    logic            lfsr_fb;
    logic [2:0]      last_target_q;
    logic [2:0]      cand_raw;
    logic [2:0]      cand;
    logic [TmoW-1:0] tmo_q;

    // Stable is updated on the same edge the counter reaches its last value, so a value held
    // for DEBOUNCE_CYCLES sampled edges becomes visible right after the last of them.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sample_q      <= 3'd0;
            deb_cnt_q     <= '0;
            stable_addr_q <= 3'd0;
        end else if (box_addr != sample_q) begin
            sample_q  <= box_addr;
            deb_cnt_q <= '0;
        end else begin
            if (deb_cnt_q != DebLast) begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
            if (deb_cnt_q >= DebPrev) begin
                stable_addr_q <= sample_q;
            end
        end
    end

    // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1
    always_comb begin
        lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};
        end
    end

    // Never repeat the previous target back to back.
    always_comb begin
        cand_raw = (lfsr_q[2:0] == 3'd0) ? 3'd1 : lfsr_q[2:0];
        if (cand_raw == last_target_q) begin
            cand = (cand_raw == 3'd7) ? 3'd1 : cand_raw + 3'd1;
        end else begin
            cand = cand_raw;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            last_target_q <= 3'd0;
            tmo_q         <= '0;
            target_box    <= 3'd0;
            round_active  <= 1'b0;
            hit           <= 1'b0;
            miss          <= 1'b0;
            score         <= 8'd0;
            rounds_left   <= 8'd0;
            game_over     <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        score       <= 8'd0;
                        rounds_left <= RoundsInit;
                        game_over   <= 1'b0;
                        state_q     <= StArm;
                    end
                end
                StArm: begin
                    last_target_q <= cand;
                    target_box    <= cand;
                    round_active  <= 1'b1;
                    tmo_q         <= '0;
                    state_q       <= StWait;
                end
                StWait: begin
                    if (stable_addr_q == last_target_q) begin
                        hit          <= 1'b1;
                        round_active <= 1'b0;
                        target_box   <= 3'd0;
                        state_q      <= StHit;
`ifdef WHACK_PENALTY_EN
                    end else if (stable_addr_q != 3'd0) begin
                        miss         <= 1'b1;
                        round_active <= 1'b0;
                        target_box   <= 3'd0;
                        state_q      <= StMiss;
`endif
                    end else if (tmo_q == TmoLast) begin
                        miss         <= 1'b1;
                        round_active <= 1'b0;
                        target_box   <= 3'd0;
                        state_q      <= StMiss;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StHit: begin
                    if (score != 8'hFF) begin
                        score <= score + 8'd1;
                    end
                    rounds_left <= rounds_left - 8'd1;
                    state_q     <= StRelease;
                end
                StMiss: begin
`ifdef WHACK_PENALTY_EN
                    if (score != 8'd0) begin
                        score <= score - 8'd1;
                    end
`endif
                    rounds_left <= rounds_left - 8'd1;
                    state_q     <= StRelease;
                end
                StRelease: begin
                    // Hold off the next round until the player lets go of the sensor.
                    if (stable_addr_q == 3'd0) begin
                        if (rounds_left == 8'd0) begin
                            game_over <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            state_q <= StArm;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Self-checking bench for whack_round_ctrl; a scoreboard holds the expected hit/miss results.
module tb_whack_round_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 20;
    localparam int unsigned RND = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] box_addr = 3'd0;
    logic [2:0] target_box;
    logic       round_active;
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [7:0] rounds_left;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       is_hit;
        logic [7:0] score;
        logic [7:0] rounds;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    bit         pend = 1'b0;
    logic [2:0] last_t;

    whack_round_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO),
        .ROUNDS         (RND),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (rst_n),
        .start       (start),
        .box_addr    (box_addr),
        .target_box  (target_box),
        .round_active(round_active),
        .hit         (hit),
        .miss        (miss),
        .score       (score),
        .rounds_left (rounds_left),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop on every pulse, then check the score/rounds update one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                pend = 1'b0;
                checks++;
                if (hit !== 1'b0 || miss !== 1'b0 || score !== cur.score ||
                    rounds_left !== cur.rounds) begin
                    errors++;
                    $display("FAIL after_pulse: hit=%0b miss=%0b score=%0d rounds_left=%0d, required 0 0 %0d %0d",
                             hit, miss, score, rounds_left, cur.score, cur.rounds);
                end
            end else if (hit === 1'b1 || miss === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: hit=%0b miss=%0b, required no pulse", hit, miss);
                end else begin
                    cur = exp_q.pop_front();
                    pend = 1'b1;
                    if (hit !== cur.is_hit || miss !== !cur.is_hit) begin
                        errors++;
                        $display("FAIL pulse_kind: hit=%0b miss=%0b, required hit=%0b miss=%0b",
                                 hit, miss, cur.is_hit, !cur.is_hit);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: time=%0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: hit the target, 1: hit a wrong box. Returns ok=0 if a bounded wait expired.
    task automatic play_round(input int mode, input logic [7:0] es, input logic [7:0] er,
                              output bit ok);
        int   n;
        exp_t e;
        logic [2:0] t;
        ok = 1'b1;
        n = 0;
        while (round_active !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (round_active !== 1'b1) begin
            ok = 1'b0;
        end else begin
            t = target_box;
            last_t = t;
            box_addr = (mode == 0) ? t : ((t == 3'd7) ? 3'd1 : t + 3'd1);
            e.is_hit = (mode == 0);
            e.score = es;
            e.rounds = er;
            exp_q.push_back(e);
            n = 0;
            while ((exp_q.size() != 0 || pend) && n < 60) begin
                tick();
                n++;
            end
            if (exp_q.size() != 0 || pend) begin
                ok = 1'b0;
                exp_q.delete();
            end
            box_addr = 3'd0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({target_box, round_active, hit, miss, score, rounds_left, game_over} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: tgt=%0d act=%0b hit=%0b miss=%0b score=%0d rl=%0d go=%0b, required all 0",
                     target_box, round_active, hit, miss, score, rounds_left, game_over);
        end
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (round_active !== 1'b0 || target_box !== 3'd0) begin
            errors++;
            $display("FAIL arm_cycle: act=%0b tgt=%0d, required 0 0", round_active, target_box);
        end
        tick();
        checks++;
        if (round_active !== 1'b1 || target_box === 3'd0 || $isunknown(target_box)) begin
            errors++;
            $display("FAIL first_target: act=%0b tgt=%0d, required 1 and 1..7", round_active, target_box);
        end
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({target_box, round_active, hit, miss, score, rounds_left, game_over} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: tgt=%0d act=%0b score=%0d rl=%0d go=%0b, required all 0",
                     target_box, round_active, score, rounds_left, game_over);
        end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (round_active !== 1'b0 || rounds_left !== 8'd0) begin
            errors++;
            $display("FAIL idle_hold: act=%0b rl=%0d, required 0 0", round_active, rounds_left);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (round_active !== 1'b1 || target_box < 3'd1 || rounds_left !== 8'd3 || score !== 8'd0) begin
            errors++;
            $display("FAIL restart_target: act=%0b tgt=%0d rl=%0d score=%0d, required 1 1..7 3 0",
                     round_active, target_box, rounds_left, score);
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   n;
        last_t = target_box;
        box_addr = last_t;
        repeat (3) tick();
        box_addr = 3'd0;
        repeat (2) tick();
        checks++;
        if (round_active !== 1'b1) begin
            errors++;
            $display("FAIL glitch_no_hit: act=%0b, required 1", round_active);
        end
        box_addr = last_t;
        e.is_hit = 1'b1;
        e.score = 8'd1;
        e.rounds = 8'd2;
        exp_q.push_back(e);
        n = 0;
        while ((exp_q.size() != 0 || pend) && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || pend) begin
            errors++;
            $display("FAIL glitch_hit_wait: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_hold_release();
        repeat (10) tick();
        checks++;
        if (round_active !== 1'b0 || target_box !== 3'd0) begin
            errors++;
            $display("FAIL held_no_arm: act=%0b tgt=%0d, required 0 0", round_active, target_box);
        end
        box_addr = 3'd0;
        repeat (5) tick();
        checks++;
        if (round_active !== 1'b0) begin
            errors++;
            $display("FAIL release_early: act=%0b, required 0", round_active);
        end
        tick();
        checks++;
        if (round_active !== 1'b1) begin
            errors++;
            $display("FAIL release_arm: act=%0b, required 1", round_active);
        end
        checks++;
        if (target_box === last_t || target_box < 3'd1 || $isunknown(target_box)) begin
            errors++;
            $display("FAIL new_target: tgt=%0d prev=%0d, required 1..7 and different", target_box, last_t);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n;
        start = 1'b1;
        e.is_hit = 1'b0;
        e.score = 8'd1;
        e.rounds = 8'd1;
        exp_q.push_back(e);
        n = 0;
        while (miss !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        start = 1'b0;
        checks++;
        if (n != 20) begin
            errors++;
            $display("FAIL timeout_cycles: cycles=%0d, required 20", n);
        end
        n = 0;
        while ((exp_q.size() != 0 || pend) && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || pend) begin
            errors++;
            $display("FAIL timeout_wait: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_game_over();
        bit ok;
        int n;
        play_round(0, 8'd2, 8'd0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL last_round: ok=%0b, required 1", ok);
        end
        n = 0;
        while (game_over !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (game_over !== 1'b1 || score !== 8'd2 || rounds_left !== 8'd0 ||
            round_active !== 1'b0 || target_box !== 3'd0) begin
            errors++;
            $display("FAIL game_over: go=%0b score=%0d rl=%0d act=%0b tgt=%0d, required 1 2 0 0 0",
                     game_over, score, rounds_left, round_active, target_box);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (score !== 8'd0 || rounds_left !== 8'd3 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart_reload: score=%0d rl=%0d go=%0b, required 0 3 0",
                     score, rounds_left, game_over);
        end
        for (int i = 0; i < 3; i++) begin
            play_round(0, 8'(i + 1), 8'(2 - i), ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_round%0d: ok=%0b, required 1", i, ok);
            end
        end
        n = 0;
        while (game_over !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (game_over !== 1'b1 || score !== 8'd3 || rounds_left !== 8'd0) begin
            errors++;
            $display("FAIL three_hits: go=%0b score=%0d rl=%0d, required 1 3 0",
                     game_over, score, rounds_left);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (score !== 8'd0 || rounds_left !== 8'd3 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL done_restart: score=%0d rl=%0d go=%0b, required 0 3 0",
                     score, rounds_left, game_over);
        end
        tick();
        checks++;
        if (round_active !== 1'b1 || target_box < 3'd1) begin
            errors++;
            $display("FAIL next_game_round: act=%0b tgt=%0d, required 1 1..7", round_active, target_box);
        end
    endtask

    task automatic test_wrong_box();
        bit ok;
        int n;
        logic [7:0] s_end;
        play_round(0, 8'd1, 8'd2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrong_setup: ok=%0b, required 1", ok);
        end
`ifdef WHACK_PENALTY_EN
        play_round(1, 8'd0, 8'd1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL penalty_miss: ok=%0b, required 1", ok);
        end
        play_round(1, 8'd0, 8'd0, ok);
        s_end = 8'd0;
`else
        play_round(1, 8'd1, 8'd1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrong_ignored: ok=%0b, required 1", ok);
        end
        play_round(1, 8'd1, 8'd0, ok);
        s_end = 8'd1;
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrong_second: ok=%0b, required 1", ok);
        end
        n = 0;
        while (game_over !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (game_over !== 1'b1 || score !== s_end) begin
            errors++;
            $display("FAIL wrong_final: go=%0b score=%0d, required 1 %0d", game_over, score, s_end);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_hold_release();
        test_timeout();
        test_game_over();
        test_back_to_back();
        test_wrong_box();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
